// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: receives 11-bit PS/2 keyboard frames (start, 8 data bits
// LSB-first, odd parity, stop). It produces validated scan codes with
// break (0xF0) and extended (0xE0) prefix tracking. It also keeps a history
// of the last four accepted codes.
// Ports:
//   clk, clr            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   asynchronous keyboard pins
//   code                last accepted scan code
//   code_valid          one-cycle pulse when code updates
//   is_break, is_ext    prefix status of code; they hold until the next code_valid
//   parity_err          one-cycle pulse on a parity failure
//   frame_err           one-cycle pulse on a bad stop bit or a mid-frame timeout
//   history             last four accepted codes, newest in [7:0]
module ps2_scan_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [7:0]  code,
    output logic        code_valid,
    output logic        is_break,
    output logic        is_ext,
    output logic        parity_err,
    output logic        frame_err,
    output logic [31:0] history
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    logic [1:0]            clk_sync_q;
    logic [1:0]            dat_sync_q;
    logic [FILTER_LEN-1:0] filt_sr_q;
    logic                  filt_clk_q, filt_clk_d;
    logic                  fall_c;
    logic                  dat_c;

    state_e                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  pend_brk_q, pend_brk_d;
    logic                  pend_ext_q, pend_ext_d;
    logic [7:0]            code_q, code_d;
    logic                  valid_q, valid_d;
    logic                  brk_q, brk_d;
    logic                  ext_q, ext_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [31:0]           hist_q, hist_d;

    // Two-flop synchronizers and the glitch filter on the keyboard clock
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_sr_q  <= '1;
            filt_clk_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            filt_sr_q  <= {filt_sr_q[FILTER_LEN-2:0], clk_sync_q[1]};
            filt_clk_q <= filt_clk_d;
        end
    end

    // Filtered level changes only after FILTER_LEN identical samples
    always_comb begin
        filt_clk_d = filt_clk_q;
        if (&filt_sr_q) begin
            filt_clk_d = 1'b1;
        end else if (~|filt_sr_q) begin
            filt_clk_d = 1'b0;
        end
    end

    // The falling edge is declared in the cycle the filter commits to 0
    assign fall_c = filt_clk_q & ~filt_clk_d;
    assign dat_c  = dat_sync_q[1];

    // State and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            pend_brk_q <= 1'b0;
            pend_ext_q <= 1'b0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            hist_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            pend_brk_q <= pend_brk_d;
            pend_ext_q <= pend_ext_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            hist_q     <= hist_d;
        end
    end

    // Frame FSM, timeout and accept logic
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        pend_brk_d = pend_brk_q;
        pend_ext_d = pend_ext_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        brk_d      = brk_q;
        ext_d      = ext_q;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        hist_d     = hist_q;

        if (state_q != ST_IDLE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (fall_c) begin
            // An edge always wins over a timeout in the same cycle
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_c) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_c, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_c;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!dat_c) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        pend_brk_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        pend_ext_d = 1'b1;
                    end else begin
                        code_d     = shift_q;
                        valid_d    = 1'b1;
                        brk_d      = pend_brk_q;
                        ext_d      = pend_ext_q;
                        pend_brk_d = 1'b0;
                        pend_ext_d = 1'b0;
                        hist_d     = {hist_q[23:0], shift_q};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // A stalled frame is dropped together with any pending prefix
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            tmo_d      = '0;
            ferr_d     = 1'b1;
            pend_brk_d = 1'b0;
            pend_ext_d = 1'b0;
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign is_break   = brk_q;
    assign is_ext     = ext_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign history    = hist_q;

endmodule
